axi_write_arbiter: RTL and testbench
====================================

// Module: axi_write_arbiter
// PURPOSE
//  Sequences every AXI write transaction through the interconnect: arbitrates AW requests from M1/M2,
//  decodes the target slave, holds the grant across the AW, W and B phases, and drives the select
//  vectors that steer the W-data and B-response muxes. Includes an internal default slave that
//  absorbs writes to unmapped addresses and answers with DECERR. Sits beside the W-data router.
// PARAMETERS
//  ADDR_W   32  address width
//  LEN_W    4   AWLEN width (burst = AWLEN+1 beats)
//  NUM_SLV  6   real slaves S0..S5; index NUM_SLV = internal default slave
// PORTS
//  clk          in   1        clock
//  rst          in   1        synchronous reset, active-high
//  AWVALID_M1   in   1        M1 write-address valid
//  AWADDR_M1    in   ADDR_W   M1 write address
//  AWLEN_M1     in   LEN_W    M1 burst length
//  AWVALID_M2   in   1        M2 write-address valid
//  AWADDR_M2    in   ADDR_W   M2 write address
//  AWLEN_M2     in   LEN_W    M2 burst length
//  AWREADY_M1   out  1        AW ready back to M1
//  AWREADY_M2   out  1        AW ready back to M2
//  AWVALID_S    out  NUM_SLV  per-slave AW valid (one-hot or zero)
//  AWREADY_S    in   NUM_SLV  per-slave AW ready
//  W_VALID      in   1        WVALID of granted master (post-mux)
//  W_READY      in   1        WREADY of selected slave (post-mux)
//  W_LAST       in   1        WLAST of granted master (post-mux)
//  BVALID_S     in   NUM_SLV  per-slave B valid
//  B_READY      in   1        BREADY of granted master (post-mux)
//  GRANT        out  2        one-hot master grant {M2,M1}
//  SLV_SEL      out  NUM_SLV+1 one-hot slave select incl. default slave (MSB)
//  DEF_WREADY   out  1        default-slave WREADY
//  DEF_BVALID   out  1        default-slave BVALID
//  DEF_BRESP    out  2        default-slave BRESP (always 2'b11 when DEF_BVALID)
//  LEN_ERR      out  1        sticky: WLAST/beat-count mismatch seen; cleared only by rst
// BEHAVIOUR
//  - Reset: state IDLE; GRANT=0, SLV_SEL=0, AWVALID_S=0, AWREADY_M*=0, DEF_*=0, LEN_ERR=0,
//    rr pointer favours M1. Reset mid-transaction abandons it; no outputs held.
//  - FSM IDLE->ADDR->DATA->RESP->IDLE; one transaction in flight, no overlap.
//  - IDLE: on any AWVALID_M*, pick winner (both valid: master not granted last; after reset M1);
//    register GRANT, AWLEN, decoded SLV_SEL; go ADDR next cycle. Arbitration latency 1 cycle.
//  - Decode (AWADDR of winner): S0 0x0000_0000-0x0000_3FFF, S1 0x0001_0000-0x0001_FFFF,
//    S2 0x0002_0000-0x0002_FFFF, S3 0x1002_0000-0x1002_03FF, S4 0x1001_0000-0x1001_03FF,
//    S5 0x2000_0000-0x201F_FFFF; anything else -> default slave.
//  - ADDR: AWVALID_S = SLV_SEL[NUM_SLV-1:0] & granted AWVALID; granted AWREADY_M = selected
//    AWREADY_S (default slave: AWREADY=1). On AW handshake -> DATA, beat_cnt=AWLEN.
//    Master dropping AWVALID before handshake: stay in ADDR (protocol violation, no abort).
//  - DATA: per W_VALID&W_READY beat, beat_cnt decrements (saturates at 0). DEF_WREADY=1 when
//    default selected. Handshake with W_LAST -> RESP; if beat_cnt!=0 then LEN_ERR<=1.
//    Handshake with beat_cnt==0 and !W_LAST -> LEN_ERR<=1, stay in DATA until W_LAST.
//  - RESP: default slave: DEF_BVALID=1, DEF_BRESP=2'b11, held until B_READY. Otherwise wait
//    BVALID_S[sel]&B_READY. On B handshake -> IDLE, GRANT/SLV_SEL cleared same edge,
//    rr pointer flips to other master. New request accepted earliest the following cycle.
//  - Grant is locked from IDLE exit until B handshake; the other master's AWREADY stays 0.
// STRUCTURE
//  - Package axi_arb_pkg: state enum (IDLE/ADDR/DATA/RESP), slave base/limit constants,
//    DEF_SLV index, BRESP_DECERR=2'b11.
//  - One sub-module: axi_addr_decoder (combinational AWADDR -> one-hot SLV_SEL incl. default).
//  - FSM, rr pointer, beat counter and default-slave logic live in the top module.
// TESTING
//  - M1 writes 0x0002_0010, AWLEN=0: GRANT=01, SLV_SEL=S2, 1 beat, BRESP from S2, back in IDLE.
//  - M1 and M2 AWVALID same cycle after reset: M1 served first; M2 granted right after M1's B.
//  - M2 burst AWLEN=3 to 0x2000_0000 with W_READY toggling: exactly 4 beats, RESP after 4th.
//  - Write to 0x3000_0000: default slave, DEF_WREADY=1, DEF_BVALID with BRESP=2'b11 until B_READY.
//  - AWLEN=3, W_LAST on beat 2: LEN_ERR=1, FSM still reaches RESP; stays 1 until rst.
//  - rst asserted in DATA: next cycle IDLE, all outputs 0; fresh M2 request served normally.

Source files
------------

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI write-path arbiter.
// The address map lives here so the decoder and any future users agree on it.
package axi_arb_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  localparam int NUM_MAP = 6;
  localparam int DEF_SLV = NUM_MAP;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  // Index 0 is the rightmost element: S5 .. S0
  localparam logic [NUM_MAP-1:0][31:0] SLV_BASE = {
    32'h2000_0000, 32'h1001_0000, 32'h1002_0000,
    32'h0002_0000, 32'h0001_0000, 32'h0000_0000
  };
  localparam logic [NUM_MAP-1:0][31:0] SLV_LIMIT = {
    32'h201F_FFFF, 32'h1001_03FF, 32'h1002_03FF,
    32'h0002_FFFF, 32'h0001_FFFF, 32'h0000_3FFF
  };

endpackage

// File: rtl/axi_addr_decoder.sv
// Combinational AWADDR -> one-hot slave select; MSB is the internal default slave,
// chosen whenever no mapped window matches.
module axi_addr_decoder
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int NUM_SLV = 6
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [NUM_SLV:0]   sel
);

  logic [NUM_SLV-1:0] hit;
  logic [ADDR_W-1:0]  off;

  // Offset compare: addresses below the base wrap to large values and miss.
  always_comb begin
    hit = '0;
    off = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      off = addr - ADDR_W'(SLV_BASE[i]);
      if (off <= ADDR_W'(SLV_LIMIT[i] - SLV_BASE[i])) hit[i] = 1'b1;
    end
  end

  assign sel = {(hit == '0), hit};

endmodule

// File: rtl/axi_write_arbiter.sv
// Write-channel sequencer: round-robin AW arbitration between two masters, grant held
// through AW/W/B, select vectors for the W/B muxes and a DECERR default slave.
module axi_write_arbiter
  import axi_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 4,
  parameter int NUM_SLV = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               AWVALID_M1,
  input  logic [ADDR_W-1:0]  AWADDR_M1,
  input  logic [LEN_W-1:0]   AWLEN_M1,
  input  logic               AWVALID_M2,
  input  logic [ADDR_W-1:0]  AWADDR_M2,
  input  logic [LEN_W-1:0]   AWLEN_M2,
  output logic               AWREADY_M1,
  output logic               AWREADY_M2,
  output logic [NUM_SLV-1:0] AWVALID_S,
  input  logic [NUM_SLV-1:0] AWREADY_S,
  input  logic               W_VALID,
  input  logic               W_READY,
  input  logic               W_LAST,
  input  logic [NUM_SLV-1:0] BVALID_S,
  input  logic               B_READY,
  output logic [1:0]         GRANT,
  output logic [NUM_SLV:0]   SLV_SEL,
  output logic               DEF_WREADY,
  output logic               DEF_BVALID,
  output logic [1:0]         DEF_BRESP,
  output logic               LEN_ERR
);

  state_t             state, state_nxt;
  logic [1:0]         grant;
  logic [NUM_SLV:0]   slv_sel, dec_sel;
  logic [LEN_W-1:0]   len, beat_cnt;
  logic               rr_m2, len_err;
  logic               req_any, pick_m2, gnt_awvalid, aw_ready_sel, def_sel;
  logic               aw_hs, w_hs, b_hs;
  logic [ADDR_W-1:0]  win_addr;
  logic [LEN_W-1:0]   win_len;

  // rr_m2 set means M2 wins a tie; it points at whoever was not granted last.
  assign req_any  = AWVALID_M1 | AWVALID_M2;
  assign pick_m2  = AWVALID_M2 & (~AWVALID_M1 | rr_m2);
  assign win_addr = pick_m2 ? AWADDR_M2 : AWADDR_M1;
  assign win_len  = pick_m2 ? AWLEN_M2  : AWLEN_M1;

  axi_addr_decoder #(.ADDR_W(ADDR_W), .NUM_SLV(NUM_SLV)) u_dec (
    .addr (win_addr),
    .sel  (dec_sel)
  );

  assign def_sel      = slv_sel[NUM_SLV];
  assign gnt_awvalid  = grant[0] ? AWVALID_M1 : AWVALID_M2;
  assign aw_ready_sel = def_sel | (|(AWREADY_S & slv_sel[NUM_SLV-1:0]));

  always_comb begin
    state_nxt  = state;
    AWVALID_S  = '0;
    AWREADY_M1 = 1'b0;
    AWREADY_M2 = 1'b0;
    DEF_WREADY = 1'b0;
    DEF_BVALID = 1'b0;
    DEF_BRESP  = BRESP_OKAY;
    aw_hs      = 1'b0;
    w_hs       = 1'b0;
    b_hs       = 1'b0;
    unique case (state)
      IDLE: if (req_any) state_nxt = ADDR;
      ADDR: begin
        AWVALID_S  = slv_sel[NUM_SLV-1:0] & {NUM_SLV{gnt_awvalid}};
        AWREADY_M1 = grant[0] & aw_ready_sel;
        AWREADY_M2 = grant[1] & aw_ready_sel;
        aw_hs      = gnt_awvalid & aw_ready_sel;
        if (aw_hs) state_nxt = DATA;
      end
      DATA: begin
        DEF_WREADY = def_sel;
        w_hs       = W_VALID & W_READY;
        if (w_hs && W_LAST) state_nxt = RESP;
      end
      RESP: begin
        DEF_BVALID = def_sel;
        DEF_BRESP  = def_sel ? BRESP_DECERR : BRESP_OKAY;
        b_hs       = B_READY & (def_sel | (|(BVALID_S & slv_sel[NUM_SLV-1:0])));
        if (b_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      slv_sel  <= '0;
      rr_m2    <= 1'b0;
      beat_cnt <= '0;
      len_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_any) begin
        grant   <= {pick_m2, ~pick_m2};
        slv_sel <= dec_sel;
      end
      if (aw_hs) beat_cnt <= len;
      if (w_hs) begin
        if (beat_cnt != '0) beat_cnt <= beat_cnt - 1'b1;
        // Early WLAST, or a further beat after the count ran out
        if (W_LAST ? (beat_cnt != '0) : (beat_cnt == '0)) len_err <= 1'b1;
      end
      if (b_hs) begin
        grant   <= '0;
        slv_sel <= '0;
        rr_m2   <= grant[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req_any) len <= win_len;
  end

  assign GRANT   = grant;
  assign SLV_SEL = slv_sel;
  assign LEN_ERR = len_err;

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Directed bench for axi_write_arbiter: arbitration, decode, bursts, default slave,
// length-error flag and mid-transaction reset.
module tb_axi_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        AWVALID_M1, AWVALID_M2;
  logic [31:0] AWADDR_M1, AWADDR_M2;
  logic [3:0]  AWLEN_M1, AWLEN_M2;
  logic        AWREADY_M1, AWREADY_M2;
  logic [5:0]  AWVALID_S, AWREADY_S, BVALID_S;
  logic        W_VALID, W_READY, W_LAST, B_READY;
  logic [1:0]  GRANT;
  logic [6:0]  SLV_SEL;
  logic        DEF_WREADY, DEF_BVALID, LEN_ERR;
  logic [1:0]  DEF_BRESP;

  int vectors = 0;
  int miscompares = 0;

  axi_write_arbiter dut (
    .clk(clk), .rst(rst),
    .AWVALID_M1(AWVALID_M1), .AWADDR_M1(AWADDR_M1), .AWLEN_M1(AWLEN_M1),
    .AWVALID_M2(AWVALID_M2), .AWADDR_M2(AWADDR_M2), .AWLEN_M2(AWLEN_M2),
    .AWREADY_M1(AWREADY_M1), .AWREADY_M2(AWREADY_M2),
    .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_LAST(W_LAST),
    .BVALID_S(BVALID_S), .B_READY(B_READY),
    .GRANT(GRANT), .SLV_SEL(SLV_SEL),
    .DEF_WREADY(DEF_WREADY), .DEF_BVALID(DEF_BVALID), .DEF_BRESP(DEF_BRESP),
    .LEN_ERR(LEN_ERR)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic last);
    W_VALID = 1'b1; W_READY = 1'b1; W_LAST = last;
    tick();
    W_VALID = 1'b0; W_READY = 1'b0; W_LAST = 1'b0;
  endtask

  task automatic bresp(input logic [5:0] bv);
    BVALID_S = bv; B_READY = 1'b1;
    tick();
    BVALID_S = '0; B_READY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    AWVALID_M1 = 0; AWADDR_M1 = '0; AWLEN_M1 = '0;
    AWVALID_M2 = 0; AWADDR_M2 = '0; AWLEN_M2 = '0;
    AWREADY_S = '0; BVALID_S = '0;
    W_VALID = 0; W_READY = 0; W_LAST = 0; B_READY = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_grant", GRANT, 0);
    chk("rst_slvsel", SLV_SEL, 0);
    chk("rst_awvalid_s", AWVALID_S, 0);
    chk("rst_awready", {AWREADY_M2, AWREADY_M1}, 0);
    chk("rst_def", {DEF_WREADY, DEF_BVALID, DEF_BRESP}, 0);
    chk("rst_lenerr", LEN_ERR, 0);

    // Single beat to S2
    AWVALID_M1 = 1; AWADDR_M1 = 32'h0002_0010; AWLEN_M1 = 0;
    #1;
    chk("t1_idle_grant", GRANT, 0);
    tick();
    chk("t1_grant", GRANT, 2'b01);
    chk("t1_slvsel", SLV_SEL, 7'h04);
    chk("t1_awvalid_s", AWVALID_S, 6'h04);
    chk("t1_awready_lo", AWREADY_M1, 0);
    AWREADY_S = 6'h04;
    #1;
    chk("t1_awready_m1", AWREADY_M1, 1);
    chk("t1_awready_m2", AWREADY_M2, 0);
    tick();
    AWVALID_M1 = 0; AWREADY_S = '0;
    #1;
    chk("t1_data_awvalid_s", AWVALID_S, 0);
    beat(1);
    chk("t1_resp_grant", GRANT, 2'b01);
    bresp(6'h04);
    chk("t1_idle_grant_clr", GRANT, 0);
    chk("t1_idle_slvsel_clr", SLV_SEL, 0);

    // Simultaneous requests after reset: M1 first, then M2 wins the tie
    rst = 1; tick(); rst = 0;
    AWVALID_M1 = 1; AWADDR_M1 = 32'h0000_0100; AWLEN_M1 = 0;
    AWVALID_M2 = 1; AWADDR_M2 = 32'h1001_0000; AWLEN_M2 = 0;
    tick();
    chk("t2_grant_m1", GRANT, 2'b01);
    chk("t2_slvsel_s0", SLV_SEL, 7'h01);
    AWREADY_S = 6'h3F;
    #1;
    chk("t2_awready_m1", AWREADY_M1, 1);
    chk("t2_awready_m2_locked", AWREADY_M2, 0);
    chk("t2_awvalid_s", AWVALID_S, 6'h01);
    tick();
    AWREADY_S = '0;
    beat(1);
    bresp(6'h01);
    chk("t2_idle", GRANT, 0);
    tick();
    chk("t2_grant_m2", GRANT, 2'b10);
    chk("t2_slvsel_s4", SLV_SEL, 7'h10);
    AWREADY_S = 6'h10;
    #1;
    chk("t2_awready_m2", AWREADY_M2, 1);
    chk("t2_awready_m1_locked", AWREADY_M1, 0);
    tick();
    AWVALID_M1 = 0; AWVALID_M2 = 0; AWREADY_S = '0;
    beat(1);
    bresp(6'h10);
    chk("t2_done", GRANT, 0);

    // M2 burst of 4 to S5 with stalls
    AWVALID_M2 = 1; AWADDR_M2 = 32'h2000_0000; AWLEN_M2 = 3;
    tick();
    chk("t3_grant", GRANT, 2'b10);
    chk("t3_slvsel_s5", SLV_SEL, 7'h20);
    AWREADY_S = 6'h20;
    tick();
    AWVALID_M2 = 0; AWREADY_S = '0;
    W_VALID = 1; W_LAST = 0;
    W_READY = 1; tick();
    W_READY = 0; tick();
    W_READY = 1; tick();
    W_READY = 0; tick();
    W_READY = 1; tick();
    W_VALID = 0; W_READY = 0;
    BVALID_S = 6'h20; B_READY = 1;
    tick();
    BVALID_S = '0; B_READY = 0;
    chk("t3_still_data", GRANT, 2'b10);
    beat(1);
    chk("t3_lenerr", LEN_ERR, 0);
    bresp(6'h20);
    chk("t3_done", GRANT, 0);

    // Unmapped address to the default slave
    AWVALID_M1 = 1; AWADDR_M1 = 32'h3000_0000; AWLEN_M1 = 1;
    tick();
    chk("t4_slvsel_def", SLV_SEL, 7'h40);
    chk("t4_awvalid_s", AWVALID_S, 0);
    chk("t4_awready_m1", AWREADY_M1, 1);
    tick();
    AWVALID_M1 = 0;
    #1;
    chk("t4_def_wready", DEF_WREADY, 1);
    beat(0);
    beat(1);
    chk("t4_resp_wready", DEF_WREADY, 0);
    chk("t4_def_bvalid", DEF_BVALID, 1);
    chk("t4_def_bresp", DEF_BRESP, 2'b11);
    tick();
    chk("t4_bvalid_held", DEF_BVALID, 1);
    chk("t4_bresp_held", DEF_BRESP, 2'b11);
    B_READY = 1; tick(); B_READY = 0;
    chk("t4_bvalid_clr", DEF_BVALID, 0);
    chk("t4_bresp_clr", DEF_BRESP, 0);
    chk("t4_done", GRANT, 0);

    // Early WLAST: AWLEN=3 but WLAST on beat 2
    AWVALID_M1 = 1; AWADDR_M1 = 32'h1002_0000; AWLEN_M1 = 3;
    tick();
    chk("t5_slvsel_s3", SLV_SEL, 7'h08);
    AWREADY_S = 6'h08;
    tick();
    AWVALID_M1 = 0; AWREADY_S = '0;
    beat(0);
    chk("t5_lenerr_lo", LEN_ERR, 0);
    beat(1);
    chk("t5_lenerr_hi", LEN_ERR, 1);
    bresp(6'h08);
    chk("t5_done", GRANT, 0);
    tick();
    chk("t5_lenerr_sticky", LEN_ERR, 1);

    // Reset during DATA, then a fresh M2 write to S1
    AWVALID_M2 = 1; AWADDR_M2 = 32'h0001_0000; AWLEN_M2 = 0;
    tick();
    AWREADY_S = 6'h02;
    tick();
    AWVALID_M2 = 0; AWREADY_S = '0;
    rst = 1; tick(); rst = 0;
    #1;
    chk("t6_grant", GRANT, 0);
    chk("t6_slvsel", SLV_SEL, 0);
    chk("t6_lenerr", LEN_ERR, 0);
    chk("t6_def", {DEF_WREADY, DEF_BVALID, DEF_BRESP}, 0);
    chk("t6_awready", {AWREADY_M2, AWREADY_M1}, 0);
    AWVALID_M2 = 1; AWADDR_M2 = 32'h0001_0004; AWLEN_M2 = 0;
    tick();
    chk("t6_new_grant", GRANT, 2'b10);
    chk("t6_new_slvsel", SLV_SEL, 7'h02);
    AWREADY_S = 6'h02;
    #1;
    chk("t6_awready_m2", AWREADY_M2, 1);
    tick();
    AWVALID_M2 = 0; AWREADY_S = '0;
    beat(1);
    bresp(6'h02);
    chk("t6_done", GRANT, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
